// File: rtl/data_memory_unit.sv
// Data memory for an RV32I datapath. It holds a word-organised RAM with byte
// lanes, two MMIO registers (a free-running cycle counter and a GPIO
// register), and a sticky access-fault capture.
module data_memory_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] GpioOut,
  output logic        AccessErr,
  output logic [31:0] ErrAddr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_cnt;
  logic [31:0]   r_gpio;
  logic          r_err;
  logic [31:0]   r_err_addr;

  logic          w_mmio;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_misal;
  logic          w_st_bad;
  logic          w_ld_bad;
  logic          w_fault;
  logic          w_st_ok;
  logic          w_ram_we;
  logic          w_gpio_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // The top 24 address bits all set select MMIO. Upper RAM index bits are
  // dropped, so RAM addresses alias modulo the RAM size.
  assign w_mmio = (ALUResult[31:8] == 24'hFFFFFF);
  assign w_idx  = ALUResult[AW+1:2];
  assign w_lane = ALUResult[1:0];

  // A fault is a misaligned half or word access, an illegal funct3 for the
  // direction, or any non-word access to MMIO.
  assign w_misal  = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                    ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  assign w_st_bad = MemWrite && (funct3[2] || (funct3[1:0] == 2'b11) || w_misal ||
                                 (w_mmio && (funct3 != 3'b010)));
  assign w_ld_bad = MemRead && ((funct3[1:0] == 2'b11) || (funct3 == 3'b110) || w_misal ||
                                (w_mmio && (funct3 != 3'b010)));
  assign w_fault  = w_st_bad || w_ld_bad;

  // Reset blocks every write. A bad store never commits.
  assign w_st_ok   = MemWrite && !w_st_bad && !reset;
  assign w_ram_we  = w_st_ok && !w_mmio;
  assign w_gpio_we = w_st_ok && w_mmio && (ALUResult[7:0] == 8'h04);

  // Compute the byte enables and replicate the store data into every lane
  // the access can target.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM byte-lane writes. Reset does not clear the RAM contents.
  always_ff @(posedge clk) begin
    if (w_ram_we)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end

  // Select the source word: RAM, or an MMIO register. Unmapped MMIO offsets read 0.
  always_comb begin
    w_word = r_mem[w_idx];
    if (w_mmio) begin
      case (ALUResult[7:0])
        8'h00:   w_word = r_cnt;
        8'h04:   w_word = r_gpio;
        default: w_word = 32'h0;
      endcase
    end
  end

  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Extend the selected lane for the load. Idle or faulting accesses return 0.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && !w_fault) begin
      case (funct3)
        3'b000:  ReadData = {{24{w_byte[7]}}, w_byte};
        3'b001:  ReadData = {{16{w_half[15]}}, w_half};
        3'b010:  ReadData = w_word;
        3'b100:  ReadData = {24'h0, w_byte};
        3'b101:  ReadData = {16'h0, w_half};
        default: ReadData = 32'h0;
      endcase
    end
  end

  // Update the cycle counter, the GPIO register and the first-fault capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 32'h0;
      r_gpio     <= 32'h0;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end else begin
      r_cnt <= r_cnt + 32'h1;
      if (w_gpio_we) r_gpio <= WriteData;
      if (w_fault && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= ALUResult;
      end
    end
  end

  assign GpioOut   = r_gpio;
  assign AccessErr = r_err;
  assign ErrAddr   = r_err_addr;

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit RAM words (power of two, 4 to 4096).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port MemWrite  input  1  store request this cycle.
REQ-005 The block SHALL have port MemRead  input  1  load request this cycle.
REQ-006 The block SHALL have port funct3  input  3  access size and signedness, per RV32I load/store encoding.
REQ-007 The block SHALL have port ALUResult  input  32  byte address from the datapath.
REQ-008 The block SHALL have port WriteData  input  32  store data, right-aligned.
REQ-009 The block SHALL have port ReadData  output  32  load data to the datapath, combinational, already extended.
REQ-010 The block SHALL have port GpioOut  output  32  memory-mapped GPIO register value.
REQ-011 The block SHALL have port AccessErr  output  1  sticky access-fault flag.
REQ-012 The block SHALL have port ErrAddr  output  32  address of the first faulting access.

Function
REQ-013 Address decode SHALL be: ALUResult[31:8]==24'hFFFFFF selects MMIO, else RAM; RAM word index = ALUResult[log2(DEPTH_WORDS)+1:2], with higher bits ignored (aliasing wrap).
REQ-014 Stores SHALL commit on the clk edge when MemWrite=1, reset=0 and no fault: sb (000) writes WriteData[7:0] to lane ALUResult[1:0]; sh (001) writes WriteData[15:0] to lane ALUResult[1]; sw (010) writes all 4 lanes; untouched lanes SHALL keep their value.
REQ-015 Loads SHALL be combinational when MemRead=1: lb (000) and lh (001) sign-extend, lw (010) passes through, lbu (100) and lhu (101) zero-extend the selected lane.
REQ-016 ReadData SHALL be 32'h0 when MemRead=0, on any faulting access, or for an undefined funct3.
REQ-017 A fault SHALL be: sh/lh/lhu with ALUResult[0]=1; sw/lw with ALUResult[1:0]!=0; funct3 not legal for the request (store: 011-111; load: 011, 110, 111); any non-word access to MMIO.
REQ-018 A faulting store SHALL modify no RAM or MMIO state.
REQ-019 On the first fault edge, AccessErr SHALL become 1 and ErrAddr SHALL capture ALUResult; later faults SHALL not update ErrAddr; both SHALL hold until reset.
REQ-020 MMIO 0xFFFFFF00 SHALL be a read-only free-running cycle counter: +1 every non-reset edge, wraps 0xFFFFFFFF->0; writes SHALL be ignored without fault.
REQ-021 MMIO 0xFFFFFF04 SHALL be the GPIO register, word read/write; GpioOut SHALL reflect it directly.
REQ-022 Other MMIO offsets SHALL read 0, and writes to them SHALL be ignored without fault.
REQ-023 With MemRead=1 and MemWrite=1 to the same location in one cycle, ReadData SHALL show the pre-write contents, and the store SHALL commit at the edge.
REQ-024 Store-to-load latency SHALL be one edge: data written at edge N is readable combinationally after edge N.
REQ-025 A counter read SHALL return the value registered at the last edge.

Reset
REQ-026 On a reset edge, the cycle counter, GpioOut, AccessErr and ErrAddr SHALL become 0.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 A store or fault presented in a reset cycle SHALL be suppressed; reset has priority over every write.
REQ-029 The counter SHALL read 0 in the first cycle after reset deassertion, and 1 after the next edge.

Verification
REQ-030 The bench SHALL cover: sw 0xDEADBEEF @0x10, then lw @0x10 -> 0xDEADBEEF; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lhu @0x10 -> 0x0000BEEF.
REQ-031 The bench SHALL cover: sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD55EF; sh 0x1234 @0x12, then lw @0x10 -> 0x123455EF.
REQ-032 The bench SHALL cover: sw @0x22 -> no write, AccessErr=1, ErrAddr=0x22; then lh @0x05 -> ErrAddr stays 0x22, ReadData=0.
REQ-033 The bench SHALL cover: with DEPTH_WORDS=256, sw 0xA5A5A5A5 @0x400, then lw @0x000 -> 0xA5A5A5A5 (wrap).
REQ-034 The bench SHALL cover: sw 0xCAFEF00D @0xFFFFFF04 -> GpioOut=0xCAFEF00D; sb @0xFFFFFF04 -> AccessErr=1, GpioOut unchanged; sw @0xFFFFFF00 -> counter unaffected.
REQ-035 The bench SHALL cover: reset asserted for 1 edge while sw 0x1 @0xFFFFFF04 is presented -> GpioOut=0, AccessErr=0; lw @0xFFFFFF00 reads 0, then 3 after 3 more edges.
